// File: rtl/snake_pkg.sv
// rtl/snake_pkg.sv - shared grid, game status, LFSR and mine FSM definitions
package snake_pkg;

    localparam int GRID_W    = 40;
    localparam int GRID_H    = 30;
    localparam int MAX_MINES = 4;

    localparam logic [1:0] GS_START     = 2'b00;
    localparam logic [1:0] GS_PLAYING   = 2'b01;
    localparam logic [1:0] GS_GAME_OVER = 2'b10;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_PICK,
        ST_COMMIT
    } mine_state_t;

    // Fibonacci step with taps 16,14,13,11 shifting towards the MSB
    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

endpackage

// File: rtl/mine_lfsr.sv
// rtl/mine_lfsr.sv - free-running 16-bit LFSR, seeded on reset
module mine_lfsr
    import snake_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] seed,
    output logic [15:0] state
);

    // Advance every clock regardless of game status; reset reloads the seed
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= seed;
        end else begin
            state <= lfsr_step(state);
        end
    end

endmodule

// File: rtl/mine_controller.sv
// rtl/mine_controller.sv - spawns, ages and collides up to four mines on the grid
module mine_controller
    import snake_pkg::*;
#(
    parameter int SPAWN_TICKS = 64,
    parameter int LIFE_TICKS  = 256,
    parameter int MAX_RETRY   = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       move_tick,
    input  logic [1:0] game_status,
    input  logic [5:0] head_x,
    input  logic [4:0] head_y,
    input  logic [5:0] apple_x,
    input  logic [4:0] apple_y,
    output logic [5:0] mine_x_0,
    output logic [5:0] mine_x_1,
    output logic [5:0] mine_x_2,
    output logic [5:0] mine_x_3,
    output logic [5:0] mine_y_0,
    output logic [5:0] mine_y_1,
    output logic [5:0] mine_y_2,
    output logic [5:0] mine_y_3,
    output logic [3:0] mine_active,
    output logic       hit_mine
);

    localparam int CNT_W   = $clog2(SPAWN_TICKS + 1);
    localparam int LIFE_W  = $clog2(LIFE_TICKS + 1);
    localparam int RETRY_W = $clog2(MAX_RETRY + 1);
    localparam int SLOT_W  = $clog2(MAX_MINES);

    mine_state_t        state_q, state_d;
    logic [15:0]        lfsr;
    logic [CNT_W-1:0]   spawn_cnt;
    logic [RETRY_W-1:0] retry;
    logic [LIFE_W-1:0]  life [MAX_MINES];
    logic [5:0]         mx   [MAX_MINES];
    logic [4:0]         my   [MAX_MINES];
    logic [3:0]         active;
    logic [5:0]         cand_x, cand_x_q;
    logic [4:0]         cand_y, cand_y_q;
    logic               reject, any_free, spawn_due, playing, starting;
    logic [SLOT_W-1:0]  free_slot;
    logic [3:0]         hit_vec;
    logic               unused_lfsr_bits;

    mine_lfsr u_lfsr (
        .clk   (clk),
        .rst   (rst),
        .seed  (LFSR_SEED),
        .state (lfsr)
    );

    assign unused_lfsr_bits = ^{lfsr[15:13], lfsr[7:6]};
    assign playing   = (game_status == GS_PLAYING);
    assign starting  = (game_status == GS_START);
    assign spawn_due = (state_q == ST_RUN) && move_tick &&
                       (spawn_cnt == CNT_W'(SPAWN_TICKS - 1));

    // Fold the raw LFSR fields onto the grid with a single conditional subtract
    always_comb begin
        cand_x = lfsr[5:0];
        cand_y = lfsr[12:8];
        if (lfsr[5:0] >= 6'(GRID_W)) cand_x = lfsr[5:0] - 6'(GRID_W);
        if (lfsr[12:8] >= 5'(GRID_H)) cand_y = lfsr[12:8] - 5'(GRID_H);
    end

    // A candidate may not land on the head, the apple or another live mine
    always_comb begin
        reject = (cand_x == head_x && cand_y == head_y) ||
                 (cand_x == apple_x && cand_y == apple_y);
        for (int i = 0; i < MAX_MINES; i++) begin
            if (active[i] && mx[i] == cand_x && my[i] == cand_y) reject = 1'b1;
        end
    end

    // Lowest-index empty slot, plus head collision per live slot on a tick
    always_comb begin
        free_slot = '0;
        any_free  = 1'b0;
        hit_vec   = '0;
        for (int i = MAX_MINES - 1; i >= 0; i--) begin
            if (!active[i]) begin
                free_slot = SLOT_W'(i);
                any_free  = 1'b1;
            end
        end
        for (int i = 0; i < MAX_MINES; i++) begin
            hit_vec[i] = move_tick && playing && active[i] &&
                         mx[i] == head_x && my[i] == head_y;
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // Next-state: leaving PLAYING always parks the FSM in IDLE
    always_comb begin
        state_d = state_q;
        if (!playing) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:   state_d = ST_RUN;
                ST_RUN:    if (spawn_due && any_free) state_d = ST_PICK;
                ST_PICK: begin
                    if (!reject)                                 state_d = ST_COMMIT;
                    else if (retry == RETRY_W'(MAX_RETRY - 1))   state_d = ST_RUN;
                end
                ST_COMMIT: state_d = ST_RUN;
                default:   state_d = ST_IDLE;
            endcase
        end
    end

    // Spawn counter, retry count, slot lifetimes and the hit pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            spawn_cnt <= '0;
            retry     <= '0;
            active    <= '0;
            hit_mine  <= 1'b0;
            cand_x_q  <= '0;
            cand_y_q  <= '0;
            for (int i = 0; i < MAX_MINES; i++) begin
                life[i] <= '0;
                mx[i]   <= '0;
                my[i]   <= '0;
            end
        end else if (starting) begin
            spawn_cnt <= '0;
            retry     <= '0;
            active    <= '0;
            hit_mine  <= 1'b0;
            for (int i = 0; i < MAX_MINES; i++) life[i] <= '0;
        end else if (!playing) begin
            hit_mine <= 1'b0;
        end else begin
            hit_mine <= |hit_vec;
            if (state_q == ST_RUN && move_tick) begin
                spawn_cnt <= spawn_due ? '0 : spawn_cnt + 1'b1;
            end
            if (state_q == ST_RUN) begin
                retry <= '0;
            end else if (state_q == ST_PICK) begin
                retry <= retry + 1'b1;
                if (!reject) begin
                    cand_x_q <= cand_x;
                    cand_y_q <= cand_y;
                end
            end
            for (int i = 0; i < MAX_MINES; i++) begin
                if (state_q == ST_COMMIT && free_slot == SLOT_W'(i)) begin
                    mx[i]     <= cand_x_q;
                    my[i]     <= cand_y_q;
                    active[i] <= 1'b1;
                    life[i]   <= LIFE_W'(LIFE_TICKS);
                end else if (hit_vec[i]) begin
                    active[i] <= 1'b0;
                    life[i]   <= '0;
                end else if (active[i] && move_tick && state_q != ST_IDLE) begin
                    life[i] <= life[i] - 1'b1;
                    if (life[i] == LIFE_W'(1)) active[i] <= 1'b0;
                end
            end
        end
    end

    assign mine_active = active;
    assign mine_x_0 = active[0] ? mx[0] : '0;
    assign mine_x_1 = active[1] ? mx[1] : '0;
    assign mine_x_2 = active[2] ? mx[2] : '0;
    assign mine_x_3 = active[3] ? mx[3] : '0;
    assign mine_y_0 = active[0] ? {1'b0, my[0]} : '0;
    assign mine_y_1 = active[1] ? {1'b0, my[1]} : '0;
    assign mine_y_2 = active[2] ? {1'b0, my[2]} : '0;
    assign mine_y_3 = active[3] ? {1'b0, my[3]} : '0;

endmodule

// File: doc/mine_controller.md
MINE_CONTROLLER -- requirements
Module: mine_controller

Interface
REQ-001 SHALL have parameters, one per line: name, default, meaning:
  SPAWN_TICKS  64   move ticks between spawn attempts
  LIFE_TICKS   256  move ticks an armed mine lives
  MAX_RETRY    8    candidate attempts per spawn
REQ-002 SHALL have ports, one per line: name  direction  width  meaning:
  clk  in  1  system clock; one clock domain, rising edge only
  rst  in  1  synchronous, active-high reset
  move_tick  in  1  one-cycle pulse per snake step
  game_status  in  2  00 START, 01 PLAYING, 10 GAME_OVER, 11 reserved (treated as GAME_OVER)
  head_x  in  6  snake head column, 0..39
  head_y  in  5  snake head row, 0..29
  apple_x  in  6  apple column
  apple_y  in  5  apple row
  mine_x_0..mine_x_3  out  6 each  mine columns
  mine_y_0..mine_y_3  out  6 each  mine rows, upper bit 0
  mine_active  out  4  bit i = slot i armed
  hit_mine  out  1  one-cycle pulse on head/mine collision

Function
REQ-003 SHALL use a 40x30 cell grid; all emitted coordinates SHALL satisfy x<=39, y<=29.
REQ-004 SHALL run a 16-bit Fibonacci LFSR, taps 16,14,13,11, advancing every clock, including outside PLAYING.
REQ-005 Candidate x SHALL be lfsr[5:0], minus 40 if >=40; candidate y SHALL be lfsr[12:8], minus 30 if >=30.
REQ-006 FSM states SHALL be IDLE, RUN, PICK, COMMIT.
REQ-007 IDLE->RUN when game_status==PLAYING. Any state->IDLE when game_status!=PLAYING.
REQ-008 In RUN, the spawn counter SHALL increment on move_tick. On reaching SPAWN_TICKS it SHALL clear to 0. If any slot is inactive, the FSM SHALL go to PICK; otherwise the attempt is skipped.
REQ-009 PICK SHALL sample one candidate per cycle. A candidate is rejected if it equals (head_x,head_y), (apple_x,apple_y), or any active mine. Rejection SHALL retry the next cycle. After MAX_RETRY rejections the FSM SHALL return to RUN with no spawn.
REQ-010 COMMIT SHALL write the accepted candidate into the lowest-index inactive slot, set its active bit, load its life counter with LIFE_TICKS, and return to RUN; total spawn latency is 2..MAX_RETRY+1 cycles after the terminal tick.
REQ-011 Each active slot SHALL decrement its life counter on move_tick in any non-IDLE state. On reaching 0, the slot SHALL clear its active bit on that same edge.
REQ-012 On a move_tick cycle with game_status==PLAYING, if head equals an active slot, hit_mine SHALL be 1 on the next cycle for exactly one cycle and that slot SHALL deactivate.
REQ-013 Hit and expiry of the same slot on the same tick: hit SHALL take priority; hit_mine pulses.
REQ-014 Multiple slots cannot share a cell (REQ-009); at most one hit per tick.
REQ-015 COMMIT and expiry/hit of a different slot on the same edge SHALL both take effect.
REQ-016 When game_status==START, all active bits, the spawn counter and all life counters SHALL be cleared. In GAME_OVER, all state SHALL freeze and outputs hold; hit_mine SHALL be 0.
REQ-017 Inactive slots SHALL drive x=0, y=0.

Reset
REQ-018 On rst: FSM=IDLE, lfsr=16'hACE1, counters=0, mine_active=0, all mine_x/mine_y=0, hit_mine=0.
REQ-019 rst mid-PICK/COMMIT SHALL abort the spawn; no slot is written.

Structure
REQ-020 A shared package snake_pkg SHALL hold GRID_W=40, GRID_H=30, MAX_MINES=4, the game_status encodings, LFSR_SEED and the FSM state typedef.
REQ-021 The LFSR SHALL be a sub-module mine_lfsr (clk, rst, seed load, 16-bit state out); all other logic stays in mine_controller.

Verification
REQ-022 Reset then hold PLAYING, issue 64 move_ticks -> slot 0 active within 9 cycles, coordinates in range, mine_active=4'b0001.
REQ-023 Force candidate == head (via lfsr preload) for 8 attempts -> no spawn, FSM back in RUN, mine_active unchanged.
REQ-024 Mine at (10,5), drive head=(10,5) with move_tick -> hit_mine=1 for exactly one cycle; bit cleared.
REQ-025 Spawn one mine, then 256 further ticks -> bit clears on the 256th tick. Same test with the head on the mine at tick 256 -> hit_mine pulses (priority check).
REQ-026 Fill all 4 slots, then 64 more ticks -> no PICK entry. Switch game_status to 10 -> outputs frozen. Switch to 00 -> mine_active=0.
REQ-027 Assert rst during PICK -> next cycle all outputs at reset values, lfsr=16'hACE1.
